// File: rtl/mips_defs.sv
// Shared definitions for the data-memory path: SRAM controller state encoding,
// bus widths and the byte-address to SRAM word-index mapping.
package mips_defs;

    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_ADDR_W       = 18;
    localparam int WORD_W            = 32;
    localparam int DEFAULT_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sram_op_t;

    // Word index of a byte address; wraps silently outside the mapped window.
    function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [WORD_W-1:0] addr,
                                                          input logic [WORD_W-1:0] base);
        return (SRAM_ADDR_W-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// half-word accesses, each held for WAIT_CYCLES cycles, freezing the pipeline meanwhile.
module sram_controller
    import mips_defs::*;
#(
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WORD_W-1:0]      address,
    input  logic [WORD_W-1:0]      writeData,
    output logic [WORD_W-1:0]      readData,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    sram_state_t            state, state_next;
    sram_op_t               op, op_next;
    logic [CNT_W-1:0]       wcnt, wcnt_next;
    logic                   last_wait;
    logic                   active;
    logic                   drive;
    logic [SRAM_ADDR_W-2:0] idx;
    logic [SRAM_DATA_W-1:0] wr_half;

    assign last_wait = (wcnt == CNT_W'(WAIT_CYCLES - 1));
    assign active    = (state == LO) || (state == HI);
    assign idx       = word_index(address, WORD_W'(BASE_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            op       <= OP_READ;
            readData <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            op    <= op_next;
            // SRAM output is sampled at the end of each half's hold window.
            if (op == OP_READ && last_wait) begin
                if (state == LO) readData[15:0]  <= SRAM_DQ;
                if (state == HI) readData[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        op_next    = op;
        case (state)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_next = LO;
                    wcnt_next  = '0;
                    op_next    = wr_en ? OP_WRITE : OP_READ;
                end
            end
            LO: begin
                if (last_wait) begin
                    state_next = HI;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            HI: begin
                if (last_wait) begin
                    state_next = DONE;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        if (state == DONE) ready = 1'b1;
        else if (state == IDLE && !wr_en && !rd_en) ready = 1'b1;
    end

    always_comb begin
        SRAM_ADDR = '0;
        if (state == LO) SRAM_ADDR = {idx, 1'b0};
        else if (state == HI) SRAM_ADDR = {idx, 1'b1};
    end

    assign drive     = active && (op == OP_WRITE);
    assign wr_half   = (state == HI) ? writeData[31:16] : writeData[15:0];
    assign SRAM_DQ   = drive ? wr_half : {SRAM_DATA_W{1'bz}};
    assign SRAM_WE_N = !drive;
    assign SRAM_OE_N = !(active && (op == OP_READ));
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 256K x 16 SRAM model.
`timescale 1ns/1ps
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_we_n, sram_oe_n;

    logic        rd_w1, rd_w4;
    logic [31:0] rdata_w1, rdata_w4;
    logic        ready_w1, ready_w4;
    wire  [15:0] dq_w1, dq_w4;
    logic [17:0] addr_w1, addr_w4;
    logic        ub_w1, lb_w1, ce_w1, we_w1, oe_w1;
    logic        ub_w4, lb_w4, ce_w4, we_w4, oe_w4;
    logic        zero_en;
    logic [31:0] zero_word;

    logic [15:0] mem [0:262143];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(write_data), .readData(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .wr_en(zero_en), .rd_en(rd_w1),
        .address(address), .writeData(zero_word), .readData(rdata_w1), .ready(ready_w1),
        .SRAM_DQ(dq_w1), .SRAM_ADDR(addr_w1), .SRAM_UB_N(ub_w1), .SRAM_LB_N(lb_w1),
        .SRAM_CE_N(ce_w1), .SRAM_WE_N(we_w1), .SRAM_OE_N(oe_w1)
    );

    sram_controller #(.WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .rst(rst), .wr_en(zero_en), .rd_en(rd_w4),
        .address(address), .writeData(zero_word), .readData(rdata_w4), .ready(ready_w4),
        .SRAM_DQ(dq_w4), .SRAM_ADDR(addr_w4), .SRAM_UB_N(ub_w4), .SRAM_LB_N(lb_w4),
        .SRAM_CE_N(ce_w4), .SRAM_WE_N(we_w4), .SRAM_OE_N(oe_w4)
    );

    // Main SRAM model: returns data when OE_N is low; an idle bus carries a 5A5A
    // marker so any stray controller drive corrupts the observed value.
    assign sram_dq = !sram_oe_n ? mem[sram_addr] : (sram_we_n ? 16'h5A5A : 16'hzzzz);
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq;
    end

    assign dq_w1 = !oe_w1 ? (addr_w1[0] ? 16'h00A5 : 16'h00C3) : 16'hzzzz;
    assign dq_w4 = !oe_w4 ? 16'h0F0F : 16'hzzzz;

    task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output int we_lo,
                          output logic [17:0] a_lo, output logic [17:0] a_hi);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        @(posedge clk);
        cyc = 0; we_lo = 0; a_lo = '0; a_hi = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!sram_we_n) we_lo++;
            if (cyc == 1) a_lo = sram_addr;
            if (cyc == 3) a_hi = sram_addr;
            if (ready || cyc >= 40) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 00000000", read_data); end
        n_checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_strobes got we=%b oe=%b want 1 1", sram_we_n, sram_oe_n); end
        n_checks++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", sram_addr); end
        n_checks++; if (sram_dq !== 16'h5A5A) begin n_fail++; $display("FAIL reset_dq got %h want 5a5a (undriven)", sram_dq); end
        n_checks++; if ({sram_ub_n, sram_lb_n, sram_ce_n} !== 3'b000) begin n_fail++; $display("FAIL reset_enables got %b want 000", {sram_ub_n, sram_lb_n, sram_ce_n}); end
    endtask

    task automatic test_write_read();
        int cyc, we_lo;
        logic [17:0] a_lo, a_hi;
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, cyc, we_lo, a_lo, a_hi);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL wr_latency got %0d want 5", cyc); end
        n_checks++; if (we_lo != 4) begin n_fail++; $display("FAIL wr_we_cycles got %0d want 4", we_lo); end
        n_checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_mem got %h %h want beef dead", mem[0], mem[1]); end
        n_checks++; if (a_lo !== 18'd0 || a_hi !== 18'd1) begin n_fail++; $display("FAIL wr_addr got %h %h want 0 1", a_lo, a_hi); end
        access(1'b0, 1'b1, 32'd1024, 32'h0, cyc, we_lo, a_lo, a_hi);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL rd_latency got %0d want 5", cyc); end
        n_checks++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", read_data); end
        n_checks++; if (we_lo != 0) begin n_fail++; $display("FAIL rd_we_cycles got %0d want 0", we_lo); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got rdy=%b data=%h want 1 deadbeef", ready, read_data); end
    endtask

    task automatic test_address_map();
        int cyc, we_lo;
        logic [17:0] a_lo, a_hi;
        access(1'b1, 1'b0, 32'd1036, 32'h11112222, cyc, we_lo, a_lo, a_hi);
        n_checks++; if (a_lo !== 18'd6 || a_hi !== 18'd7) begin n_fail++; $display("FAIL map_1036 got %h %h want 6 7", a_lo, a_hi); end
        n_checks++; if (mem[6] !== 16'h2222 || mem[7] !== 16'h1111) begin n_fail++; $display("FAIL map_1036_mem got %h %h want 2222 1111", mem[6], mem[7]); end
        access(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, cyc, we_lo, a_lo, a_hi);
        n_checks++; if (a_lo !== 18'h3FFFE || a_hi !== 18'h3FFFF) begin n_fail++; $display("FAIL map_wrap got %h %h want 3fffe 3ffff", a_lo, a_hi); end
        n_checks++; if (mem[262142] !== 16'hF00D || mem[262143] !== 16'hCAFE) begin n_fail++; $display("FAIL map_wrap_mem got %h %h want f00d cafe", mem[262142], mem[262143]); end
    endtask

    task automatic test_simultaneous();
        int cyc, we_lo;
        logic [17:0] a_lo, a_hi;
        access(1'b1, 1'b1, 32'd1040, 32'h12345678, cyc, we_lo, a_lo, a_hi);
        n_checks++; if (we_lo != 4) begin n_fail++; $display("FAIL both_we_cycles got %0d want 4", we_lo); end
        n_checks++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_rdata got %h want deadbeef", read_data); end
        n_checks++; if (mem[8] !== 16'h5678 || mem[9] !== 16'h1234) begin n_fail++; $display("FAIL both_mem got %h %h want 5678 1234", mem[8], mem[9]); end
    endtask

    task automatic test_back_to_back();
        int cyc, we_lo, p;
        int pc [2];
        logic [31:0] pd [2];
        logic [17:0] a_lo, a_hi;
        access(1'b1, 1'b0, 32'd1028, 32'h44443333, cyc, we_lo, a_lo, a_hi);
        pc[0] = -1; pc[1] = -1; pd[0] = '0; pd[1] = '0; p = 0;
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1024;
        for (int c = 1; c <= 30 && p < 2; c++) begin
            @(negedge clk);
            if (ready) begin
                pc[p] = c; pd[p] = read_data; p++;
                if (p == 1) address = 32'd1028;
                else rd_en = 1'b0;
            end
        end
        rd_en = 1'b0;
        n_checks++; if (pc[0] != 5 || pc[1] != 11) begin n_fail++; $display("FAIL b2b_pulses got %0d %0d want 5 11", pc[0], pc[1]); end
        n_checks++; if (pd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_data0 got %h want deadbeef", pd[0]); end
        n_checks++; if (pd[1] !== 32'h44443333) begin n_fail++; $display("FAIL b2b_data1 got %h want 44443333", pd[1]); end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1044; write_data = 32'h9ABCDEF0;
        @(posedge clk);
        repeat (4) @(negedge clk);
        n_checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd11) begin n_fail++; $display("FAIL midrst_pre got we=%b addr=%h want 0 b", sram_we_n, sram_addr); end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL midrst_strobes got we=%b oe=%b want 1 1", sram_we_n, sram_oe_n); end
        n_checks++; if (sram_dq !== 16'h5A5A) begin n_fail++; $display("FAIL midrst_dq got %h want 5a5a (undriven)", sram_dq); end
        n_checks++; if (ready !== 1'b1 || read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_state got rdy=%b data=%h want 1 00000000", ready, read_data); end
        n_checks++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", sram_addr); end
    endtask

    task automatic test_wait_cycles();
        int c1, c4;
        c1 = -1; c4 = -1;
        @(negedge clk);
        rd_w1 = 1'b1; address = 32'd1024;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready_w1) begin c1 = c; break; end
        end
        rd_w1 = 1'b0;
        n_checks++; if (c1 != 3) begin n_fail++; $display("FAIL w1_latency got %0d want 3", c1); end
        n_checks++; if (rdata_w1 !== 32'h00A500C3) begin n_fail++; $display("FAIL w1_rdata got %h want 00a500c3", rdata_w1); end
        @(negedge clk);
        rd_w4 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (addr_w4 !== 18'd0 || we_w4 !== 1'b1 || oe_w4 !== 1'b0) begin n_fail++; $display("FAIL w4_drive got addr=%h we=%b oe=%b want 0 1 0", addr_w4, we_w4, oe_w4); end
            end
            if (ready_w4) begin c4 = c; break; end
        end
        rd_w4 = 1'b0;
        n_checks++; if (c4 != 9) begin n_fail++; $display("FAIL w4_latency got %0d want 9", c4); end
        n_checks++; if (rdata_w4 !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL w4_rdata got %h want 0f0f0f0f", rdata_w4); end
        n_checks++; if ({ub_w1, lb_w1, ce_w1, we_w1, oe_w1, ub_w4, lb_w4, ce_w4} !== 8'b00011000) begin
            n_fail++; $display("FAIL wx_idle_pins got %b want 00011000", {ub_w1, lb_w1, ce_w1, we_w1, oe_w1, ub_w4, lb_w4, ce_w4});
        end
        n_checks++; if (addr_w1 !== 18'h0) begin n_fail++; $display("FAIL w1_idle_addr got %h want 0", addr_w1); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        rd_w1 = 1'b0; rd_w4 = 1'b0; zero_en = 1'b0; zero_word = '0;
        test_reset();
        test_write_read();
        test_address_map();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_write();
        test_wait_cycles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
